// File: rtl/vga_pkg.sv
// Shared constants and fetch-state encoding for the VGA frame-buffer read path.
package vga_pkg;
  localparam int H_ACT       = 640;
  localparam int V_ACT       = 480;
  localparam int PIX_W       = 16;
  localparam int FRAME_WORDS = H_ACT * V_ACT;

  typedef enum logic [1:0] {IDLE, REQ, DATA, FLUSH} fetch_state_t;
endpackage

// File: rtl/vga_fetch_fifo.sv
// Single-clock prefetch FIFO with a registered read port and synchronous clear.
module vga_fetch_fifo import vga_pkg::*; #(
  parameter int DEPTH = 64,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             vga_clk,
  input  logic             sys_rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [PIX_W-1:0] data_i,
  output logic [PIX_W-1:0] data_o,
  output logic [LVL_W-1:0] level_o,
  output logic             empty_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [LVL_W-1:0] level_q;
  logic [PIX_W-1:0] dout_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (level_q != LVL_W'(DEPTH));
  assign do_pop  = pop_i && (level_q != '0);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      dout_q  <= '0;
    end else if (clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop) begin
        rptr_q <= rptr_q + PTR_W'(1);
        dout_q <= mem_q[rptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (do_push && !clear_i) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = dout_q;
  assign level_o = level_q;
  assign empty_o = (level_q == '0);
endmodule

// File: rtl/vga_line_fetch.sv
// Burst-read scheduler keeping the prefetch FIFO ahead of the VGA display;
// realigns to the frame base on every vsync falling edge.
module vga_line_fetch #(
  parameter int H_ACT      = vga_pkg::H_ACT,
  parameter int V_ACT      = vga_pkg::V_ACT,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W     = 21,
  parameter int BASE_ADDR  = 0
) (
  input  logic                        vga_clk,
  input  logic                        sys_rst_n,
  input  logic                        pix_data_req,
  input  logic                        vsync,
  output logic [15:0]                 pix_data,
  output logic                        mem_rd_req,
  output logic [ADDR_W-1:0]           mem_rd_addr,
  input  logic                        mem_rd_ack,
  input  logic                        mem_rd_valid,
  input  logic [15:0]                 mem_rd_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underflow
);
  import vga_pkg::*;

  localparam int FRM_WORDS = H_ACT * V_ACT;
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int BCNT_W    = $clog2(BURST_LEN) + 1;
  localparam int WRD_W     = $clog2(FRM_WORDS + 1);

  fetch_state_t      state_q;
  logic              vsync_q, req_q, drain_q, zero_q, uf_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WRD_W-1:0]  words_q;
  logic [BCNT_W-1:0] beat_q, beat_inc;
  logic              frame_start, flushing, push, pop, under_req, space_ok, last_beat;
  logic [15:0]       fifo_dout;
  logic              fifo_empty;
  logic [LVL_W-1:0]  level;

  assign frame_start = vsync_q & ~vsync;
  assign flushing    = (state_q == FLUSH);
  assign push        = (state_q == DATA) && mem_rd_valid;
  assign pop         = pix_data_req && !fifo_empty && !flushing;
  assign under_req   = pix_data_req && !pop;
  assign space_ok    = (LVL_W'(FIFO_DEPTH) - level) >= LVL_W'(BURST_LEN);
  assign beat_inc    = beat_q + BCNT_W'(mem_rd_valid);
  assign last_beat   = mem_rd_valid && (beat_inc == BCNT_W'(BURST_LEN));

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      vsync_q <= 1'b1;
      req_q   <= 1'b0;
      drain_q <= 1'b0;
      addr_q  <= ADDR_W'(BASE_ADDR);
      words_q <= '0;
      beat_q  <= '0;
    end else begin
      vsync_q <= vsync;
      if (frame_start && !flushing) begin
        // A burst already granted by memory must be drained, not abandoned.
        state_q <= FLUSH;
        case (state_q)
          REQ: if (mem_rd_ack) begin
            req_q   <= 1'b0;
            drain_q <= 1'b1;
            beat_q  <= '0;
          end
          DATA: begin
            beat_q  <= beat_inc;
            drain_q <= !last_beat;
          end
          default: ;
        endcase
      end else begin
        case (state_q)
          IDLE: if (words_q < WRD_W'(FRM_WORDS) && space_ok) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
          REQ: if (mem_rd_ack) begin
            req_q   <= 1'b0;
            beat_q  <= '0;
            state_q <= DATA;
          end
          DATA: if (mem_rd_valid) begin
            beat_q <= beat_inc;
            if (last_beat) begin
              addr_q  <= addr_q + ADDR_W'(BURST_LEN);
              words_q <= words_q + WRD_W'(BURST_LEN);
              state_q <= IDLE;
            end
          end
          FLUSH: begin
            if (req_q) begin
              // Address stays stable while the request is still outstanding.
              if (mem_rd_ack) begin
                req_q   <= 1'b0;
                drain_q <= 1'b1;
                beat_q  <= '0;
              end
            end else begin
              addr_q  <= ADDR_W'(BASE_ADDR);
              words_q <= '0;
              if (!drain_q) begin
                state_q <= IDLE;
              end else if (last_beat) begin
                drain_q <= 1'b0;
                state_q <= IDLE;
              end else begin
                beat_q <= beat_inc;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      zero_q <= 1'b0;
      uf_q   <= 1'b0;
    end else begin
      if (pop)            zero_q <= 1'b0;
      else if (under_req) zero_q <= 1'b1;
      if (under_req)      uf_q   <= 1'b1;
      else if (flushing)  uf_q   <= 1'b0;
    end
  end

  vga_fetch_fifo #(.DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_fifo (
    .vga_clk  (vga_clk),
    .sys_rst_n(sys_rst_n),
    .push_i   (push),
    .pop_i    (pop),
    .clear_i  (flushing),
    .data_i   (mem_rd_data),
    .data_o   (fifo_dout),
    .level_o  (level),
    .empty_o  (fifo_empty)
  );

  assign pix_data    = zero_q ? 16'h0000 : fifo_dout;
  assign mem_rd_req  = req_q;
  assign mem_rd_addr = addr_q;
  assign fifo_level  = level;
  assign underflow   = uf_q;
endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch: a 1-cycle-ack memory model returning addr-valued
// beats, with scenario tasks for reset, fill, drain, underflow, mid-burst vsync and frame end.
module tb_vga_line_fetch;
  localparam int BL = 16;
  localparam int AW = 21;
  localparam int FRM_BURSTS = (640 * 2) / BL;

  logic          vga_clk = 1'b0;
  logic          sys_rst_n, pix_data_req, vsync;
  logic          mem_rd_ack = 1'b0, mem_rd_valid = 1'b0;
  logic [15:0]   mem_rd_data = '0;
  logic [15:0]   pix_data;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic [6:0]    fifo_level;
  logic          underflow;

  int tests = 0, fails = 0;
  logic          mem_en = 1'b1;
  int            beats_left = 0, bidx = 0;
  logic [AW-1:0] burst_base = '0;
  logic [AW-1:0] req_log[$];

  always #5 vga_clk = ~vga_clk;

  vga_line_fetch #(
    .H_ACT(640), .V_ACT(2), .BURST_LEN(BL), .FIFO_DEPTH(64), .ADDR_W(AW), .BASE_ADDR(0)
  ) dut (
    .vga_clk     (vga_clk),
    .sys_rst_n   (sys_rst_n),
    .pix_data_req(pix_data_req),
    .vsync       (vsync),
    .pix_data    (pix_data),
    .mem_rd_req  (mem_rd_req),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_ack  (mem_rd_ack),
    .mem_rd_valid(mem_rd_valid),
    .mem_rd_data (mem_rd_data),
    .fifo_level  (fifo_level),
    .underflow   (underflow)
  );

  // Memory: ack one cycle after req, then BL back-to-back beats whose data is their word address.
  always @(negedge vga_clk) begin
    if (!sys_rst_n) begin
      mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; beats_left = 0;
    end else begin
      if (mem_rd_ack) begin
        mem_rd_ack = 1'b0; beats_left = BL; bidx = 0;
      end else if (mem_rd_req && mem_en && beats_left == 0) begin
        mem_rd_ack = 1'b1; burst_base = mem_rd_addr; req_log.push_back(mem_rd_addr);
      end
      if (beats_left > 0) begin
        mem_rd_valid = 1'b1; mem_rd_data = burst_base[15:0] + 16'(bidx);
        bidx++; beats_left--;
      end else begin
        mem_rd_valid = 1'b0;
      end
    end
  end

  task automatic wait_level_full(input string name);
    int t = 0;
    while (fifo_level != 7'd64 && t < 400) begin @(posedge vga_clk); #1; t++; end
    if (t >= 400) begin tests++; fails++; $display("FAIL %s: fifo_level=%0d never reached 64", name, fifo_level); end
  endtask

  task automatic test_reset();
    int t = 0;
    sys_rst_n = 1'b0; vsync = 1'b1; pix_data_req = 1'b0; mem_en = 1'b1;
    repeat (3) @(negedge vga_clk);
    sys_rst_n = 1'b1;
    do begin @(posedge vga_clk); #1; t++; end while (bidx != 5 && t < 100);
    if (t >= 100) begin tests++; fails++; $display("FAIL reset_midburst: beat 5 never seen"); end
    #2 sys_rst_n = 1'b0;
    #1;
    tests++; if (mem_rd_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", mem_rd_req); end
    tests++; if (pix_data !== 16'h0) begin fails++; $display("FAIL reset_pix: got %h want 0000", pix_data); end
    tests++; if (fifo_level !== 7'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL reset_uf: got %b want 0", underflow); end
    repeat (2) @(negedge vga_clk);
    req_log.delete();
    sys_rst_n = 1'b1;
    t = 0;
    do begin @(posedge vga_clk); #1; t++; end while (!mem_rd_req && t < 20);
    tests++;
    if (mem_rd_req !== 1'b1 || mem_rd_addr !== '0) begin
      fails++; $display("FAIL reset_first_req: req=%b addr=%0d want req=1 addr=0", mem_rd_req, mem_rd_addr);
    end
  endtask

  task automatic test_fill();
    int hits = 0;
    wait_level_full("fill_level");
    repeat (30) begin @(posedge vga_clk); #1; if (mem_rd_req) hits++; end
    tests++; if (req_log.size() != 4) begin fails++; $display("FAIL fill_count: got %0d bursts want 4", req_log.size()); end
    for (int i = 0; i < 4 && i < req_log.size(); i++) begin
      tests++;
      if (req_log[i] !== AW'(16 * i)) begin fails++; $display("FAIL fill_addr%0d: got %0d want %0d", i, req_log[i], 16 * i); end
    end
    tests++; if (hits != 0) begin fails++; $display("FAIL fill_idle: mem_rd_req high %0d cycles want 0", hits); end
  endtask

  task automatic test_drain();
    int n_req = 0, n_chk = 0, bad = 0, bad_at = -1;
    logic prev = 1'b0;
    logic [15:0] bad_val = '0;
    req_log.delete();
    // 16 requests per 18 cycles matches what a 1-cycle-ack memory can refill.
    for (int c = 0; c < 800 && (n_req < 640 || prev); c++) begin
      @(negedge vga_clk);
      if (prev) begin
        if (pix_data !== n_chk[15:0]) begin
          if (bad == 0) begin bad_at = n_chk; bad_val = pix_data; end
          bad++;
        end
        n_chk++;
      end
      prev = (n_req < 640) && ((c % 18) < 16);
      pix_data_req = prev;
      if (prev) n_req++;
    end
    pix_data_req = 1'b0;
    tests++; if (bad != 0) begin fails++; $display("FAIL drain_data: %0d wrong, first at %0d got %0d", bad, bad_at, bad_val); end
    tests++; if (n_chk != 640) begin fails++; $display("FAIL drain_count: checked %0d want 640", n_chk); end
    tests++;
    if (req_log.size() < 2 || req_log[0] !== AW'(64) || req_log[1] !== AW'(80)) begin
      fails++; $display("FAIL drain_refill: first refills not 64,80 (count %0d)", req_log.size());
    end
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL drain_uf: got %b want 0", underflow); end
  endtask

  task automatic test_underflow();
    int t = 0;
    mem_en = 1'b0;
    repeat (40) @(negedge vga_clk);
    forever begin
      @(negedge vga_clk);
      if (fifo_level == 7'd0 || t >= 100) break;
      pix_data_req = 1'b1; t++;
    end
    pix_data_req = 1'b0;
    tests++; if (fifo_level !== 7'd0 || underflow !== 1'b0) begin
      fails++; $display("FAIL uf_empty: level=%0d uf=%b want 0,0", fifo_level, underflow);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge vga_clk); pix_data_req = 1'b1;
      @(negedge vga_clk); pix_data_req = 1'b0;
      tests++;
      if (pix_data !== 16'h0000 || underflow !== 1'b1) begin
        fails++; $display("FAIL uf_pulse%0d: pix=%h uf=%b want 0000,1", k, pix_data, underflow);
      end
    end
    repeat (10) @(negedge vga_clk);
    tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL uf_sticky: got %b want 1", underflow); end
    vsync = 1'b0;
    repeat (2) @(negedge vga_clk);
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL uf_clear: got %b want 0", underflow); end
    mem_en = 1'b1;
    vsync = 1'b1;
  endtask

  task automatic test_midburst_vsync();
    int t = 0;
    do begin @(posedge vga_clk); #1; t++; end while (!(mem_rd_req && mem_rd_addr == AW'(32)) && t < 300);
    t = 0;
    do begin @(posedge vga_clk); #1; t++; end while (!(bidx == 5 && beats_left > 0) && t < 50);
    if (t >= 50) begin tests++; fails++; $display("FAIL mid_setup: burst at 32 never reached beat 5"); end
    vsync = 1'b0;
    t = 0;
    do begin @(posedge vga_clk); #1; t++; end while (!(bidx == 16 && beats_left == 0) && t < 50);
    tests++;
    if (fifo_level !== 7'd0 || mem_rd_req !== 1'b0) begin
      fails++; $display("FAIL mid_discard: level=%0d req=%b want 0,0", fifo_level, mem_rd_req);
    end
    @(posedge vga_clk); #1;
    tests++;
    if (mem_rd_req !== 1'b1 || mem_rd_addr !== '0) begin
      fails++; $display("FAIL mid_restart: req=%b addr=%0d want 1,0", mem_rd_req, mem_rd_addr);
    end
    vsync = 1'b1;
  endtask

  task automatic test_end_of_frame();
    int t = 0, c = 0, hits = 0;
    wait_level_full("eof_prefill");
    @(negedge vga_clk); vsync = 1'b0;
    do begin @(posedge vga_clk); #1; t++; end while (!(mem_rd_req && mem_rd_addr == '0) && t < 20);
    req_log.delete();
    vsync = 1'b1;
    wait_level_full("eof_fill");
    t = 0;
    while (req_log.size() < FRM_BURSTS && t < 3000) begin
      @(negedge vga_clk); pix_data_req = (c % 18) < 16; c++; t++;
    end
    repeat (40) begin @(negedge vga_clk); pix_data_req = (c % 18) < 16; c++; end
    pix_data_req = 1'b0;
    repeat (100) begin @(negedge vga_clk); if (mem_rd_req) hits++; end
    tests++; if (req_log.size() != FRM_BURSTS) begin fails++; $display("FAIL eof_count: got %0d bursts want %0d", req_log.size(), FRM_BURSTS); end
    tests++;
    if (req_log.size() == 0 || req_log[req_log.size()-1] !== AW'(1264)) begin
      fails++; $display("FAIL eof_last_addr: last burst address wrong (count %0d)", req_log.size());
    end
    tests++; if (hits != 0) begin fails++; $display("FAIL eof_quiet: mem_rd_req high %0d cycles want 0", hits); end
    vsync = 1'b0;
    t = 0;
    do begin @(posedge vga_clk); #1; t++; end while (!mem_rd_req && t < 10);
    tests++;
    if (mem_rd_req !== 1'b1 || mem_rd_addr !== '0) begin
      fails++; $display("FAIL eof_restart: req=%b addr=%0d want 1,0", mem_rd_req, mem_rd_addr);
    end
    vsync = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_underflow();
    test_midburst_vsync();
    test_end_of_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
